// File: rtl/branch_eval_arbiter.sv
// Round-robin arbiter that shares one branch-condition evaluator among NUM_REQ
// requesters, returning a tagged taken/illegal response one cycle after grant.
module branch_eval_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int ID_W    = 3
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [6*NUM_REQ-1:0]  req_opcode,
    input  logic [5*NUM_REQ-1:0]  req_rt,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic                  resp_taken,
    output logic                  resp_illegal
);

    typedef enum logic [5:0] {
        OP_REGIMM = 6'b000001,
        OP_BEQ    = 6'b000100,
        OP_BNE    = 6'b000101,
        OP_BLEZ   = 6'b000110,
        OP_BGTZ   = 6'b000111
    } branch_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    logic [5:0]  op_arr [NUM_REQ];
    logic [4:0]  rt_arr [NUM_REQ];
    logic [31:0] a_arr  [NUM_REQ];
    logic [31:0] b_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_opcode[6*g +: 6];
        assign rt_arr[g] = req_rt[5*g +: 5];
        assign a_arr[g]  = req_a[32*g +: 32];
        assign b_arr[g]  = req_b[32*g +: 32];
    end

    slot_state_e        state_q;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q;
    logic [5:0]         opcode_q;
    logic [4:0]         rt_q;
    logic signed [31:0] a_q, b_q;

    logic               accept;
    logic               found;
    logic [ID_W-1:0]    winner;
    logic               taken_raw, illegal_raw;

    assign resp_valid = (state_q == SLOT_FULL);
    assign accept     = Rst_n && (|req) && (!resp_valid || resp_ready);
    assign ptr_d      = winner + ID_W'(1);

    // Scan from the pointer upward; the ID_W-bit index wraps modulo NUM_REQ by itself.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [ID_W-1:0] idx;
            idx = ptr_q + ID_W'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (accept) gnt[winner] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!Rst_n) begin
            state_q  <= SLOT_EMPTY;
            ptr_q    <= '0;
            id_q     <= '0;
            opcode_q <= '0;
            rt_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else if (accept) begin
            state_q  <= SLOT_FULL;
            ptr_q    <= ptr_d;
            id_q     <= winner;
            opcode_q <= op_arr[winner];
            rt_q     <= rt_arr[winner];
            a_q      <= a_arr[winner];
            b_q      <= b_arr[winner];
        end else if (resp_ready) begin
            state_q  <= SLOT_EMPTY;
        end
    end

    always_comb begin
        taken_raw   = 1'b0;
        illegal_raw = 1'b0;
        case (opcode_q)
            OP_REGIMM: taken_raw = (rt_q == 5'b00001) ? (a_q >= 0) : (a_q < 0);
            OP_BEQ:    taken_raw = (a_q == b_q);
            OP_BNE:    taken_raw = (a_q != b_q);
            OP_BGTZ:   taken_raw = (a_q > 0);
            OP_BLEZ:   taken_raw = (a_q <= 0);
            default:   illegal_raw = 1'b1;
        endcase
    end

    // Gated by the slot so the cleared operand registers do not report an illegal opcode.
    assign resp_id      = id_q;
    assign resp_taken   = resp_valid && taken_raw;
    assign resp_illegal = resp_valid && illegal_raw;

endmodule

// File: tb/tb_branch_eval_arbiter.sv
// Self-checking bench for branch_eval_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_branch_eval_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic            resp_ready = 1'b1;
    logic [5:0]      op_v [N];
    logic [4:0]      rt_v [N];
    logic [31:0]     a_v  [N];
    logic [31:0]     b_v  [N];

    logic [6*N-1:0]  req_opcode;
    logic [5*N-1:0]  req_rt;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]    gnt;
    logic            resp_valid, resp_taken, resp_illegal;
    logic [IW-1:0]   resp_id;

    always #5 Clk = ~Clk;

    always_comb begin
        req_opcode = '0;
        req_rt     = '0;
        req_a      = '0;
        req_b      = '0;
        for (int i = 0; i < N; i++) begin
            req_opcode[6*i +: 6] = op_v[i];
            req_rt[5*i +: 5]     = rt_v[i];
            req_a[32*i +: 32]    = a_v[i];
            req_b[32*i +: 32]    = b_v[i];
        end
    end

    branch_eval_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .req(req),
        .req_opcode(req_opcode), .req_rt(req_rt), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_taken(resp_taken), .resp_illegal(resp_illegal)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one response slot plus the rotating priority pointer.
    bit          m_valid = 1'b0;
    int          m_id = 0, m_ptr = 0;
    logic [5:0]  m_op = '0;
    logic [4:0]  m_rt = '0;
    logic [31:0] m_a = '0, m_b = '0;
    int          wait_cnt [N];
    bit          fair_on = 1'b0;
    logic [N-1:0] seen_gnt;
    bit          pend [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_eval(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output bit t, output bit il);
        int sa, sb;
        sa = a;
        sb = b;
        t  = 1'b0;
        il = 1'b0;
        case (op)
            6'd1:    t = (rt == 5'd1) ? (sa >= 0) : (sa < 0);
            6'd4:    t = (sa == sb);
            6'd5:    t = (sa != sb);
            6'd7:    t = (sa > 0);
            6'd6:    t = (sa <= 0);
            default: il = 1'b1;
        endcase
    endfunction

    function automatic int ref_winner();
        if (!Rst_n || req == '0 || (m_valid && !resp_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Compare at the falling edge, then advance the model at the rising edge.
    task automatic step();
        int w;
        bit t, il;
        logic [N-1:0] e;
        @(negedge Clk);
        w = ref_winner();
        e = '0;
        if (w >= 0) e[w] = 1'b1;
        ref_eval(m_op, m_rt, m_a, m_b, t, il);
        check("gnt", 32'(gnt), 32'(e));
        check("resp_valid", 32'(resp_valid), 32'(m_valid));
        check("resp_id", 32'(resp_id), 32'(m_id));
        check("resp_taken", 32'(resp_taken), 32'(m_valid && t));
        check("resp_illegal", 32'(resp_illegal), 32'(m_valid && il));
        seen_gnt = gnt;
        @(posedge Clk);
        if (!Rst_n) begin
            m_valid = 1'b0; m_ptr = 0; m_id = 0;
            m_op = '0; m_rt = '0; m_a = '0; m_b = '0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else if (w >= 0) begin
            if (fair_on) begin
                check("fair_wait", 32'(wait_cnt[w] < N), 32'd1);
                for (int i = 0; i < N; i++) if (req[i] && i != w) wait_cnt[i]++;
                wait_cnt[w] = 0;
            end
            m_op = op_v[w]; m_rt = rt_v[w]; m_a = a_v[w]; m_b = b_v[w];
            m_id = w; m_ptr = (w + 1) % N; m_valid = 1'b1;
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        req   = '0;
        step();
        Rst_n = 1'b1;
    endtask

    task automatic one_req(input string tag, input int idx, input logic [5:0] op,
                           input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b,
                           input bit exp_t, input bit exp_il);
        logic [N-1:0] e;
        e = '0;
        e[idx] = 1'b1;
        req = e;
        op_v[idx] = op; rt_v[idx] = rt; a_v[idx] = a; b_v[idx] = b;
        #1;
        check({tag, "_gnt"}, 32'(gnt), 32'(e));
        step();
        req = '0;
        check({tag, "_taken"}, 32'(resp_taken), 32'(exp_t));
        check({tag, "_illegal"}, 32'(resp_illegal), 32'(exp_il));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            op_v[i] = 6'd4; rt_v[i] = '0; a_v[i] = i; b_v[i] = i; wait_cnt[i] = 0; pend[i] = 1'b0;
        end

        // Reset state.
        step();
        step();
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        Rst_n = 1'b1;

        // First transaction: BEQ with equal operands.
        one_req("beq_eq", 0, 6'b000100, 5'd0, 32'h5, 32'h5, 1'b1, 1'b0);
        check("beq_eq_id", 32'(resp_id), 32'd0);
        check("beq_eq_valid", 32'(resp_valid), 32'd1);

        // Sign handling and the remaining opcodes.
        one_req("bgez_neg", 3, 6'b000001, 5'b00001, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        one_req("bltz_neg", 3, 6'b000001, 5'b00000, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        one_req("bgtz_min", 3, 6'b000111, 5'b00000, 32'h80000000, 32'h0, 1'b0, 1'b0);
        one_req("blez_zero", 3, 6'b000110, 5'b00000, 32'h0, 32'h0, 1'b1, 1'b0);
        one_req("bne_diff", 6, 6'b000101, 5'b00000, 32'h1, 32'h2, 1'b1, 1'b0);
        one_req("beq_diff", 1, 6'b000100, 5'b00000, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0);
        one_req("jump", 0, 6'b000010, 5'b00000, 32'h0, 32'h0, 1'b0, 1'b1);
        step();

        // All requesters held: strict rotation with no bubbles.
        do_reset();
        req = '1;
        for (int k = 0; k < N + 1; k++) begin
            #1;
            check("rr_gnt", 32'(gnt), 32'd1 << (k % N));
            if (k > 0) begin
                check("rr_valid", 32'(resp_valid), 32'd1);
                check("rr_id", 32'(resp_id), 32'((k - 1) % N));
            end
            step();
        end
        req = '0;
        step();

        // Backpressure: requester 2 answered, downstream stalls while 4 and 5 wait.
        do_reset();
        req = 8'h04;
        step();
        req = 8'h30;
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_gnt", 32'(gnt), 32'd0);
            check("bp_id", 32'(resp_id), 32'd2);
            check("bp_valid", 32'(resp_valid), 32'd1);
            step();
        end
        resp_ready = 1'b1;
        #1;
        check("bp_resume_gnt", 32'(gnt), 32'h10);
        step();
        check("bp_resume_id", 32'(resp_id), 32'd4);
        req = 8'h20;
        step();
        req = '0;
        step();

        // Reset pulse with a live response and pointer at 5.
        do_reset();
        req = 8'h10;
        step();
        req = 8'h81;
        Rst_n = 1'b0;
        #1;
        check("rp_gnt_in_reset", 32'(gnt), 32'd0);
        step();
        check("rp_valid", 32'(resp_valid), 32'd0);
        Rst_n = 1'b1;
        #1;
        check("rp_first_gnt", 32'(gnt), 32'h01);
        step();
        req = 8'h80;
        step();
        req = '0;
        step();

        // Randomized traffic obeying the hold-until-granted rule.
        do_reset();
        fair_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (seen_gnt[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    case ($urandom_range(7))
                        0, 5:    op_v[i] = 6'b000001;
                        1:       op_v[i] = 6'b000100;
                        2:       op_v[i] = 6'b000101;
                        3:       op_v[i] = 6'b000110;
                        4:       op_v[i] = 6'b000111;
                        6:       op_v[i] = 6'($urandom);
                        default: op_v[i] = 6'b000010;
                    endcase
                    rt_v[i] = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(1));
                    case ($urandom_range(5))
                        0:       a_v[i] = 32'h0;
                        1:       a_v[i] = 32'h80000000;
                        2:       a_v[i] = 32'hFFFFFFFF;
                        3:       a_v[i] = 32'h1;
                        4:       a_v[i] = 32'h7FFFFFFF;
                        default: a_v[i] = $urandom;
                    endcase
                    b_v[i] = ($urandom_range(1) == 0) ? a_v[i] : $urandom;
                end
                req[i] = pend[i];
            end
            resp_ready = ($urandom_range(3) != 0);
            Rst_n = ($urandom_range(199) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_eval_arbiter.md
Name: branch_eval_arbiter

Overview:
- Shares one branch-condition evaluator among NUM_REQ core-side requesters in the multi-core processor.
- Each core's decode stage raises a request carrying its opcode, instruction bits [20:16] and the two register operands.
- The block picks one requester per cycle by round-robin and registers its operands.
- It evaluates the branch condition and returns a tagged taken/not-taken response one cycle after grant, with downstream backpressure.

Parameters:
- NUM_REQ, 8, number of requesters; must be a power of two, 2..16.
- ID_W, 3, requester index width; equals log2(NUM_REQ).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  reset, synchronous, active-low.
- req  input  NUM_REQ  per-requester request, level; held until granted.
- req_opcode  input  6*NUM_REQ  opcode, requester i at bits [6i+5:6i].
- req_rt  input  5*NUM_REQ  instruction bits [20:16], requester i at [5i+4:5i].
- req_a  input  32*NUM_REQ  operand A, requester i at [32i+31:32i].
- req_b  input  32*NUM_REQ  operand B, same packing as req_a.
- gnt  output  NUM_REQ  one-hot, combinational; operands of the granted requester are captured at this edge.
- resp_valid  output  1  response holding register is valid.
- resp_ready  input  1  downstream accepts the response this cycle.
- resp_id  output  ID_W  index of the requester being answered.
- resp_taken  output  1  branch condition true.
- resp_illegal  output  1  opcode is not a branch opcode; resp_taken is 0 in that case.

Behaviour:
- Reset (Rst_n low at a rising edge):
  - resp_valid=0, resp_id=0, resp_taken=0, resp_illegal=0, operand registers cleared.
  - Round-robin pointer = 0, meaning requester 0 has highest priority.
  - gnt=0 while Rst_n is low.
  - Reset mid-operation discards any registered response; a requester whose grant was lost in reset must still see its req acknowledged later, i.e. it keeps req high.
- Pipeline: two states per slot, EMPTY and FULL (resp_valid).
  - accept = (|req) && (!resp_valid || resp_ready).
  - gnt is nonzero only when accept is true.
- Arbitration:
  - Search starts at the pointer and wraps modulo NUM_REQ; the first asserted req wins.
  - On accept, the pointer becomes winner+1, wrapping to 0 after NUM_REQ-1.
  - With no accept, the pointer holds.
- Capture: on accept, latch the winner's opcode, rt, A and B. resp_id=winner. resp_valid=1 from the next cycle.
- Evaluation uses the registered operands; resp_taken/resp_illegal are combinational from them. Signed 32-bit compares:
  - opcode 000001, rt==00001: A>=0.
  - opcode 000001, any other rt: A<0.
  - 000100: A==B.
  - 000101: A!=B.
  - 000111: A>0.
  - 000110: A<=0.
  - Any other opcode: taken=0, illegal=1.
- Handshake:
  - A response completes on a cycle with resp_valid && resp_ready.
  - Same-cycle completion and accept are allowed, giving throughput of 1 per cycle.
  - Completion without accept: resp_valid falls to 0.
  - resp_valid && !resp_ready: all response outputs hold stable, gnt=0, pointer holds.
- Latency: grant at edge N; response valid from cycle N+1; minimum round trip 1 cycle.
- Requester rule: a requester may drop req only after seeing its gnt bit. The block does not check requester protocol violations.
- Simultaneous events:
  - Requests arriving during a stall wait.
  - After the stall, priority is still computed from the held pointer.
  - No requester waits more than NUM_REQ accepts once it is asserted.

Test Plan:
- Reset, then req=8'h01, opcode 000100, A=B=32'h5 → gnt=8'h01 in the same cycle; next cycle resp_valid=1, resp_id=0, resp_taken=1, resp_illegal=0.
- Sign handling on requester 3, opcode 000001:
  - rt=00001, A=32'hFFFFFFFF → taken=0.
  - rt=00000, same A → taken=1.
  - opcode 000111, A=32'h80000000 → taken=0.
  - opcode 000110, A=0 → taken=1.
- req=8'hFF held, resp_ready=1 → grants 0,1,...,7,0 on consecutive cycles; resp_id follows one cycle behind; no bubbles.
- Backpressure: requester 2 is granted, then resp_ready=0 for 3 cycles while req=8'h30 → gnt=0 and outputs stable; when ready=1, gnt=8'h10 that cycle and the response for requester 4 follows.
- Opcode 000010 (jump) → resp_illegal=1, resp_taken=0.
- Reset pulse while resp_valid=1 and req=8'h81 with pointer=5 → resp_valid=0 next cycle and pointer=0; the first grant after reset goes to requester 0 (gnt=8'h01).
